// File: rtl/demux_pkg.sv
// Shared lane-count and lane-index definitions for the 1-to-8 stream distributor.
// Optional build macro used by the top: DEMUX8_RR_EN (round-robin lane selection).
package demux_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] lane_idx_t;

endpackage

// File: rtl/lane_buf.sv
// One-entry register slice: a load always wins over a same-cycle drain.
// Latency one cycle; full throughput when drained and reloaded on the same edge.
module lane_buf #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         drain,
  output logic [N-1:0] data,
  output logic         valid
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/stream_demux8.sv
// Registered 1-to-8 stream distributor with per-lane one-entry holding registers.
// DEMUX8_RR_EN: ignore in_sel and steer by a round-robin pointer exposed on rr_ptr.
module stream_demux8
  import demux_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic [2:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out0,
  output logic [N-1:0] out1,
  output logic [N-1:0] out2,
  output logic [N-1:0] out3,
  output logic [N-1:0] out4,
  output logic [N-1:0] out5,
  output logic [N-1:0] out6,
  output logic [N-1:0] out7,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready
`ifdef DEMUX8_RR_EN
  ,
  output logic [2:0]   rr_ptr
`endif
);

  lane_idx_t        dest;
  logic             accept;
  logic [LANES-1:0] valid_w;
  logic [LANES-1:0] load_w;
  logic [LANES-1:0] drain_w;
  logic [N-1:0]     lane_data [LANES];

`ifdef DEMUX8_RR_EN
  lane_idx_t rr_ptr_q, rr_ptr_d;
  logic      unused_sel;

  assign unused_sel = ^in_sel;
  assign dest       = rr_ptr_q;
  assign rr_ptr_d   = accept ? rr_ptr_q + lane_idx_t'(1) : rr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign dest = in_sel;
`endif

  // Ready never looks at in_valid, so the producer may wait on it without a loop.
  assign in_ready = ~rst & (~valid_w[dest] | out_ready[dest]);
  assign accept   = in_valid & in_ready;
  assign load_w   = accept ? ({{(LANES-1){1'b0}}, 1'b1} << dest) : '0;
  assign drain_w  = valid_w & out_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_buf #(.N(N)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (load_w[k]),
      .load_data (in_data),
      .drain     (drain_w[k]),
      .data      (lane_data[k]),
      .valid     (valid_w[k])
    );
  end

  assign out_valid = valid_w;
  assign out0 = lane_data[0];
  assign out1 = lane_data[1];
  assign out2 = lane_data[2];
  assign out3 = lane_data[3];
  assign out4 = lane_data[4];
  assign out5 = lane_data[5];
  assign out6 = lane_data[6];
  assign out7 = lane_data[7];

endmodule

// File: tb/tb_stream_demux8.sv
// Directed plus random bench for stream_demux8 against a per-lane occupancy model.
module tb_stream_demux8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [2:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
`ifdef DEMUX8_RR_EN
  logic [2:0]  rr_ptr;
`endif

  stream_demux8 #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX8_RR_EN
    ,
    .rr_ptr    (rr_ptr)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] dout [8];
  assign dout[0] = out0;
  assign dout[1] = out1;
  assign dout[2] = out2;
  assign dout[3] = out3;
  assign dout[4] = out4;
  assign dout[5] = out5;
  assign dout[6] = out6;
  assign dout[7] = out7;

  // Reference state: which lanes hold a word, what word, and where round-robin points.
  logic [7:0]  exp_valid;
  logic [31:0] exp_data [8];
  int          exp_rr;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_valid = '0;
    exp_rr    = 0;
    for (int k = 0; k < 8; k++) exp_data[k] = '0;
  endtask

  task automatic check_outputs();
    check("out_valid", {24'd0, out_valid}, {24'd0, exp_valid});
    for (int k = 0; k < 8; k++) check($sformatf("out%0d", k), dout[k], exp_data[k]);
`ifdef DEMUX8_RR_EN
    check("rr_ptr", {29'd0, rr_ptr}, exp_rr);
`endif
  endtask

  // Caller sets inputs shortly after a rising edge; this runs one full clock.
  task automatic cycle();
    int          d;
    logic        rdy, acc;
    logic [31:0] word;
    logic [7:0]  ordy;
    @(negedge clk);
`ifdef DEMUX8_RR_EN
    d = exp_rr;
`else
    d = int'(in_sel);
`endif
    rdy  = !exp_valid[d] || out_ready[d];
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc  = in_valid && rdy;
    word = in_data;
    ordy = out_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      if (acc && d == k) begin
        exp_data[k]  = word;
        exp_valid[k] = 1'b1;
      end else if (ordy[k]) begin
        exp_valid[k] = 1'b0;
      end
    end
    if (acc) exp_rr = (exp_rr + 1) % 8;
    check_outputs();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_clear();
    check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    check_outputs();
    @(posedge clk);
    #1;
    check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #2;
    check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    check_outputs();
    do_reset();

`ifndef DEMUX8_RR_EN
    // Basic steer to lane 3
    in_sel = 3'd3; in_data = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 8'h00;
    cycle();
    check("steer_out3", out3, 32'hDEADBEEF);
    check("steer_valid", {24'd0, out_valid}, 32'h08);

    // Backpressure on lane 6
    in_sel = 3'd6; in_data = 32'h66666666;
    cycle();
    in_data = 32'h77777777;
    #1;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    cycle();
    check("bp_hold_out6", out6, 32'h66666666);
    out_ready = 8'h40;
    #1;
    check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    cycle();
    check("bp_replace_out6", out6, 32'h77777777);
    check("bp_valid6", {31'd0, out_valid[6]}, 32'd1);

    // Flush, then stream 0..7 at full rate
    in_valid = 1'b0; out_ready = 8'hFF;
    cycle();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i); in_data = 32'(i);
      #1;
      check("stream_ready", {31'd0, in_ready}, 32'd1);
      cycle();
      check("stream_out", dout[i], 32'(i));
    end

    // Independent drain of lanes 0 and 7
    out_ready = 8'h00;
    in_sel = 3'd0; in_data = 32'hA5A5_0000;
    cycle();
    in_sel = 3'd7; in_data = 32'hA5A5_0007;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("drain_before", {24'd0, out_valid}, 32'h81);
    out_ready = 8'h81;
    cycle();
    check("drain_after", {24'd0, out_valid}, 32'h00);

    // Reset with lanes 2 and 5 full, then every lane accepts again
    out_ready = 8'h00; in_valid = 1'b1;
    in_sel = 3'd2; in_data = 32'h22;
    cycle();
    in_sel = 3'd5; in_data = 32'h55;
    cycle();
    in_valid = 1'b0;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i); in_data = 32'h100 + 32'(i);
      cycle();
    end
    check("post_reset_all_full", {24'd0, out_valid}, 32'hFF);
    in_valid = 1'b0; out_ready = 8'hFF;
    cycle();
`else
    // Ten words with in_sel forced to 0 wrap around the lanes
    out_ready = 8'hFF; in_valid = 1'b1; in_sel = 3'd0;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'hA0 + 32'(i);
      cycle();
      check("rr_word", dout[i % 8], 32'hA0 + 32'(i));
    end
    in_valid = 1'b0;
    cycle();
    check("rr_end_ptr", {29'd0, rr_ptr}, 32'd2);

    // Stall on a full lane 2 even though lane 3 is empty
    out_ready = 8'hFB; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'hB0 + 32'(i);
      cycle();
    end
    in_data = 32'hC0;
    #1;
    check("rr_stall_ready", {31'd0, in_ready}, 32'd0);
    check("rr_lane3_empty", {31'd0, out_valid[3]}, 32'd0);
    check("rr_stall_ptr", {29'd0, rr_ptr}, 32'd2);
    cycle();
    out_ready = 8'hFF;
    cycle();
    check("rr_after_stall", out2, 32'hC0);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = $urandom;
      out_ready = 8'($urandom);
      cycle();
    end

    in_valid = 1'b0;
    do_reset();
    out_ready = 8'h00;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux8.md
Name: stream_demux8

Overview:
- Registered 1-to-8 stream distributor; the inverse of the 8-to-1 datapath select.
- Accepts one N-bit word per cycle on a valid/ready input and steers it to one of eight output lanes.
- Each lane has a one-entry holding register with its own valid/ready handshake.
- Used to fan a single producer (e.g. a result bus) out to per-unit consumers without combinational paths from input to outputs.

Parameters:
N, 32, data width of the input word and of every output lane

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_data  input  N  word to distribute
in_sel  input  3  destination lane index 0..7 (ignored when DEMUX8_RR_EN is defined)
in_valid  input  1  producer has a word
in_ready  output  1  block can accept the word this cycle
out0..out7  output  N each  lane holding-register contents
out_valid  output  8  bit k = lane k holds an unconsumed word
out_ready  input  8  bit k = consumer k takes lane k's word this cycle
rr_ptr  output  3  current round-robin lane; present only with DEMUX8_RR_EN

Behaviour:
- Reset (asynchronous, active-high): out0..out7 = 0, out_valid = 8'h00, rr_ptr = 0. While rst is high, in_ready = 0.
- Destination lane d = in_sel, or rr_ptr with DEMUX8_RR_EN.
- Lane k full flag = out_valid[k]. Drain_k = out_valid[k] & out_ready[k].
- in_ready = !out_valid[d] | out_ready[d]. This is combinational from out_valid, out_ready, in_sel and rr_ptr only, never from in_valid.
- Accept = in_valid & in_ready. On the clock edge, lane d data <= in_data and out_valid[d] <= 1.
- On drain_k without a same-cycle accept into lane k: out_valid[k] <= 0. Data is held; no clearing required.
- Simultaneous drain and accept on the same lane: the new word is loaded and out_valid stays 1. Full throughput is one word per cycle per lane.
- Latency: a word accepted at edge t is visible on out_d after edge t. Minimum one cycle, with no combinational input-to-output data path.
- Lanes are independent. Any subset of out_ready may be high, and drains on other lanes proceed regardless of input activity.
- out_ready[k] while out_valid[k] = 0 has no effect.
- in_sel changing while in_valid is high and in_ready is low is legal. The word is re-steered; there is no requirement to hold in_sel stable.
- Output data and out_valid are stable while out_valid[k] = 1 and out_ready[k] = 0.
- Reset asserted mid-transfer: all lanes are emptied immediately and pending words are lost.

Optional Feature:
- Macro: DEMUX8_RR_EN.
- Defined:
  - in_sel is ignored.
  - A 3-bit rr_ptr selects the lane.
  - rr_ptr increments by 1 on every accept and wraps 7 -> 0.
  - rr_ptr holds when there is no accept.
  - in_ready reflects lane rr_ptr only. The block stalls on a full rr_ptr lane even if other lanes are empty, preserving strict order.
- Not defined: in_sel steers, there is no rr_ptr port, and no pointer register exists.

Decomposition:
- Package demux_pkg:
  - localparam LANES = 8, SEL_W = 3.
  - typedef logic [SEL_W-1:0] lane_idx_t.
- Sub-module lane_buf (parameter N):
  - One-entry register slice with ports clk, rst, load, load_data, drain, data, valid.
  - Instantiated 8 times.
- Top level contains only the destination decode, the in_ready select and the optional rr_ptr counter.

Test Plan:
- Reset: assert rst mid-simulation with lanes 2 and 5 full -> out_valid = 8'h00, out0..out7 = 0, in_ready = 0 during reset; all lanes accept again after release.
- Basic steer: in_sel = 3, in_data = 32'hDEADBEEF, in_valid = 1 for one cycle, out_ready = 0 -> out3 = 32'hDEADBEEF, out_valid = 8'h08 next cycle; all other lanes unchanged.
- Backpressure: lane 6 full, out_ready[6] = 0, in_sel = 6, in_valid = 1 -> in_ready = 0 and lane 6 keeps its old word. Raise out_ready[6] -> in_ready = 1 and the new word replaces the old one in the same edge, with out_valid[6] remaining 1.
- Streaming: 8 consecutive words 0..7 with in_sel = i and all out_ready = 1 -> in_ready stays 1 every cycle and outk = k one cycle after its accept.
- Independent drain: lanes 0 and 7 full, out_ready = 8'h81, no input -> out_valid goes from 8'h81 to 8'h00 after one edge.
- DEMUX8_RR_EN:
  - Send 10 words A0..A9 with all out_ready = 1 and in_sel = 0 forced -> words land in lanes 0..7, 0, 1, and rr_ptr ends at 2.
  - Hold out_ready[2] = 0 with lane 2 full -> in_ready = 0 even though lane 3 is empty.
